udp_jpeg_pkt_ctrl: RTL and testbench

- Upstream feeder for the 128-bit UDP byte serializer.
- Splits one JPEG frame stored in DDR3 into UDP packets of at most PKT_BYTES payload bytes.
- Prefetches 128-bit DDR3 words into a small FIFO and hands them to the serializer, one word per rising edge of its update request.
- Drives per-packet header fields (rank, last flag, length, IPv4 ident) and starts and sequences one serializer transaction per packet.

---
 rtl/udp_pkg.sv | 11 +
 rtl/udp_word_fifo.sv | 40 ++++
 rtl/udp_jpeg_pkt_ctrl.sv | 154 +++++++++++++++
 tb/tb_udp_jpeg_pkt_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/udp_pkg.sv
// udp_pkg: shared state type and packet-size arithmetic for the UDP JPEG feeder.
package udp_pkg;
    typedef enum logic [1:0] {S_IDLE, S_FILL, S_SEND, S_NEXT} state_e;
    localparam int unsigned WORD_BYTES = 16;
    function automatic logic [23:0] pkt_len(input logic [23:0] rem, input int unsigned max_bytes);
        return (rem > 24'(max_bytes)) ? 24'(max_bytes) : rem;
    endfunction
    function automatic logic [20:0] pkt_words(input logic [23:0] len);
        return 21'((25'(len) + 25'(WORD_BYTES - 1)) / 25'(WORD_BYTES));
    endfunction
endpackage

// File: rtl/udp_word_fifo.sv
// udp_word_fifo: DEPTH x 128-bit synchronous FIFO; the head word is presented combinationally.
module udp_word_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [127:0]             data_i,
    input  logic                     pop_i,
    output logic [127:0]             data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    logic [127:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;
    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign do_pop  = pop_i && !empty_o;
    // a full FIFO still takes a push when the same cycle frees a slot
    assign do_push = push_i && (!full_o || do_pop);
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_q];
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) mem_q[wr_q] <= data_i;
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/udp_jpeg_pkt_ctrl.sv
// udp_jpeg_pkt_ctrl: splits a DDR3-resident JPEG frame into UDP packets, prefetching
// 128-bit words for the serializer and sequencing one serializer transaction per packet.
module udp_jpeg_pkt_ctrl
    import udp_pkg::*;
#(
    parameter int unsigned PKT_BYTES  = 1024,
    parameter int unsigned ADDR_W     = 28,
    parameter int unsigned ADDR_STEP  = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              i_udp_clk50m,
    input  logic              i_rst,
    input  logic              i_frame_start,
    input  logic [ADDR_W-1:0] i_frame_addr,
    input  logic [23:0]       i_frame_len,
    output logic              o_frame_busy,
    output logic              o_frame_done,
    output logic              o_ddr_rd_req,
    output logic [ADDR_W-1:0] o_ddr_rd_addr,
    input  logic              i_ddr_rd_valid,
    input  logic [127:0]      i_ddr_rd_data,
    output logic [127:0]      o_ddr3_udp_wrdata,
    input  logic              i_ddr3_data_upd_req,
    output logic              o_send_en,
    input  logic              i_udp_frame_down,
    output logic              o_udp_last_frame_flag,
    output logic [14:0]       o_mjpeg_frame_rank,
    output logic [15:0]       o_udp_jpeg_len,
    output logic [15:0]       o_udp_ipv4_sign,
    output logic              o_underflow
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [20:0]       fetch_q, fetch_d, words, fill_need;
    logic [23:0]       rem_q, rem_d, cur_len;
    logic [14:0]       rank_q, rank_d;
    logic [15:0]       ipv4_q, ipv4_d, len_q, len_d;
    logic              last_q, last_d, send_q, send_d, done_q, done_d, upd_q, unf_q, unf_d;
    logic [CW-1:0]     outst_q, outst_d, fifo_cnt;
    logic              fifo_empty, fifo_full, push, pop, issue;

    udp_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (i_udp_clk50m),
        .rst_i   (i_rst),
        .push_i  (push),
        .data_i  (i_ddr_rd_data),
        .pop_i   (pop),
        .data_o  (o_ddr3_udp_wrdata),
        .count_o (fifo_cnt),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign cur_len   = pkt_len(rem_q, PKT_BYTES);
    assign words     = pkt_words(cur_len);
    assign fill_need = (words < 21'(FIFO_DEPTH)) ? words : 21'(FIFO_DEPTH);
    // responses with nothing outstanding belong to a frame discarded by reset
    assign push  = i_ddr_rd_valid && outst_q != '0;
    assign pop   = i_ddr3_data_upd_req && !upd_q;
    assign issue = state_q != S_IDLE && fetch_q != '0 && !fifo_full &&
                   (CW+1)'(fifo_cnt) + (CW+1)'(outst_q) < (CW+1)'(FIFO_DEPTH);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        fetch_d = fetch_q;
        rem_d   = rem_q;
        rank_d  = rank_q;
        ipv4_d  = ipv4_q;
        len_d   = len_q;
        last_d  = last_q;
        send_d  = send_q;
        done_d  = 1'b0;
        unf_d   = unf_q || (pop && fifo_empty);
        outst_d = outst_q + CW'(issue) - CW'(push);
        if (issue) begin
            addr_d  = addr_q + ADDR_W'(ADDR_STEP);
            fetch_d = fetch_q - 21'd1;
        end
        case (state_q)
            S_IDLE: if (i_frame_start) begin
                done_d = i_frame_len == '0;
                if (i_frame_len != '0) begin
                    state_d = S_FILL;
                    addr_d  = i_frame_addr;
                    rem_d   = i_frame_len;
                    fetch_d = pkt_words(i_frame_len);
                    rank_d  = '0;
                end
            end
            S_FILL: if (21'(fifo_cnt) >= fill_need) begin
                len_d   = 16'(cur_len);
                last_d  = rem_q == cur_len;
                send_d  = 1'b1;
                state_d = S_SEND;
            end
            S_SEND: if (i_udp_frame_down) begin
                send_d  = 1'b0;
                state_d = S_NEXT;
            end
            default: begin
                rem_d   = rem_q - cur_len;
                rank_d  = rank_q + 15'd1;
                ipv4_d  = ipv4_q + 16'd1;
                state_d = (rem_d != '0) ? S_FILL : S_IDLE;
                done_d  = rem_d == '0;
            end
        endcase
    end

    always_ff @(posedge i_udp_clk50m) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            fetch_q <= '0;
            rem_q   <= '0;
            rank_q  <= '0;
            ipv4_q  <= '0;
            len_q   <= '0;
            last_q  <= 1'b0;
            send_q  <= 1'b0;
            done_q  <= 1'b0;
            upd_q   <= 1'b0;
            unf_q   <= 1'b0;
            outst_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            fetch_q <= fetch_d;
            rem_q   <= rem_d;
            rank_q  <= rank_d;
            ipv4_q  <= ipv4_d;
            len_q   <= len_d;
            last_q  <= last_d;
            send_q  <= send_d;
            done_q  <= done_d;
            upd_q   <= i_ddr3_data_upd_req;
            unf_q   <= unf_d;
            outst_q <= outst_d;
        end
    end

    assign o_frame_busy          = state_q != S_IDLE;
    assign o_frame_done          = done_q;
    assign o_ddr_rd_req          = issue;
    assign o_ddr_rd_addr         = addr_q;
    assign o_send_en             = send_q;
    assign o_udp_last_frame_flag = last_q;
    assign o_mjpeg_frame_rank    = rank_q;
    assign o_udp_jpeg_len        = len_q;
    assign o_udp_ipv4_sign       = ipv4_q;
    assign o_underflow           = unf_q;
endmodule

// File: tb/tb_udp_jpeg_pkt_ctrl.sv
// tb_udp_jpeg_pkt_ctrl: randomized bench with a DDR3 responder and serializer model,
// checked against packet arithmetic computed directly from frame length and base address.
module tb_udp_jpeg_pkt_ctrl;
    localparam int PKT  = 1024;
    localparam int STEP = 8;

    logic         clk = 0, rst = 1;
    logic         frame_start = 0, ddr_valid = 0, upd = 0, frame_down = 0;
    logic [27:0]  frame_addr = 0;
    logic [23:0]  frame_len = 0;
    logic [127:0] ddr_data = 0;
    logic         busy, done, rd_req, send_en, last_flag, underflow;
    logic [27:0]  rd_addr;
    logic [127:0] wrdata;
    logic [14:0]  rank_o;
    logic [15:0]  jpeg_len, ipv4;

    udp_jpeg_pkt_ctrl dut (
        .i_udp_clk50m          (clk),
        .i_rst                 (rst),
        .i_frame_start         (frame_start),
        .i_frame_addr          (frame_addr),
        .i_frame_len           (frame_len),
        .o_frame_busy          (busy),
        .o_frame_done          (done),
        .o_ddr_rd_req          (rd_req),
        .o_ddr_rd_addr         (rd_addr),
        .i_ddr_rd_valid        (ddr_valid),
        .i_ddr_rd_data         (ddr_data),
        .o_ddr3_udp_wrdata     (wrdata),
        .i_ddr3_data_upd_req   (upd),
        .o_send_en             (send_en),
        .i_udp_frame_down      (frame_down),
        .o_udp_last_frame_flag (last_flag),
        .o_mjpeg_frame_rank    (rank_o),
        .o_udp_jpeg_len        (jpeg_len),
        .o_udp_ipv4_sign       (ipv4),
        .o_underflow           (underflow)
    );

    always #5 clk = ~clk;

    int checks = 0, fails = 0;
    int cyc = 0;
    int lat_min = 1, lat_max = 4;
    int req_cnt = 0;
    int ipv4_exp = 0;
    logic [27:0] exp_base = 0;
    logic [31:0] salt = 0;

    typedef struct {int due; logic [27:0] a;} rsp_t;
    rsp_t rq[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] ddr_word(input logic [27:0] a);
        return {{4'h0, a}, ~{4'h0, a}, salt, {4'h0, a} * 32'd7};
    endfunction

    // DDR3 responder: in-order replies after a random latency, request addresses checked
    initial begin
        forever begin
            @(negedge clk);
            ddr_valid = 0;
            if (rq.size() != 0 && rq[0].due <= cyc) begin
                ddr_valid = 1;
                ddr_data  = ddr_word(rq[0].a);
                void'(rq.pop_front());
            end
            if (rd_req) begin
                chk("rd_addr", rd_addr, exp_base + 28'(STEP * req_cnt));
                req_cnt++;
                rq.push_back('{cyc + int'($urandom_range(lat_min, lat_max)), rd_addr});
            end
        end
    end

    task automatic wait_send(output bit ok);
        ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            ok = send_en;
        end
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic pop_word(input int hi, input int lo, input bit chk_adv, input logic [27:0] next_a);
        upd = 1;
        @(negedge clk);
        if (chk_adv) chk("adv", wrdata, ddr_word(next_a));
        repeat (hi - 1) @(negedge clk);
        if (chk_adv && hi > 1) chk("hold", wrdata, ddr_word(next_a));
        upd = 0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic run_frame(input logic [27:0] base, input int len, input int hi, input int lo,
                             input bit chk_data, input bit poke_start);
        int rem, rank, widx, total, l, w;
        bit ok;
        rem = len; rank = 0; widx = 0; total = (len + 15) / 16;
        exp_base = base; req_cnt = 0;
        frame_addr = base; frame_len = 24'(len); frame_start = 1;
        @(negedge clk);
        frame_start = 0;
        if (len == 0) begin
            chk("zero_done", done, 1);
            chk("zero_busy", busy, 0);
            @(negedge clk);
            chk("zero_done_once", done, 0);
            chk("zero_reads", req_cnt, 0);
            return;
        end
        chk("busy", busy, 1);
        while (rem > 0) begin
            l = rem < PKT ? rem : PKT;
            w = (l + 15) / 16;
            wait_send(ok);
            if (!ok) return;
            chk("len", jpeg_len, l);
            chk("last", last_flag, rem == l);
            chk("rank", rank_o, rank);
            chk("ipv4", ipv4, 16'(ipv4_exp));
            if (poke_start && rank == 0) begin
                frame_addr = 0; frame_len = 24'd16; frame_start = 1;
                @(negedge clk);
                frame_start = 0;
            end
            for (int k = 0; k < w; k++) begin
                if (chk_data) chk("head", wrdata, ddr_word(base + 28'(STEP * widx)));
                widx++;
                pop_word(hi, lo, chk_data && widx < total, base + 28'(STEP * widx));
            end
            frame_down = 1;
            @(negedge clk);
            frame_down = 0;
            chk("send_off", send_en, 0);
            @(negedge clk);
            chk("done", done, rem == l);
            rem -= l; rank++; ipv4_exp++;
        end
        @(negedge clk);
        chk("done_once", done, 0);
        chk("idle", busy, 0);
        if (chk_data) chk("reads", req_cnt, total);
    endtask

    initial begin
        bit ok;
        salt = $urandom;
        repeat (3) @(negedge clk);
        chk("rst_ctl", {busy, done, rd_req, send_en, last_flag, underflow}, 0);
        chk("rst_hdr", {rank_o, jpeg_len, ipv4}, 0);
        chk("rst_word", wrdata, 0);
        rst = 0;
        @(negedge clk);
        run_frame(28'h0100000, 3000, 2, 2, 1, 1);
        run_frame(28'($urandom_range(0, 1 << 20)) * 8, 20, 1, 3, 1, 0);
        run_frame(28'($urandom_range(0, 1 << 20)) * 8, $urandom_range(100, 2500), 4, 2, 1, 0);
        run_frame(28'h0000040, 0, 1, 1, 1, 0);
        frame_down = 1;
        @(negedge clk);
        frame_down = 0;
        @(negedge clk);
        chk("stray_down", {busy, send_en, done}, 0);
        for (int i = 0; i < 2; i++)
            run_frame(28'($urandom_range(0, 1 << 20)) * 8, $urandom_range(1, 3000),
                      $urandom_range(1, 3), $urandom_range(2, 3), 1, 0);
        chk("no_underflow", underflow, 0);
        lat_min = 30; lat_max = 30;
        run_frame(28'h0200000, 2048, 1, 1, 0, 0);
        chk("underflow", underflow, 1);
        repeat (5) @(negedge clk);
        chk("underflow_sticky", underflow, 1);
        lat_min = 1; lat_max = 6;
        exp_base = 28'h0300000; req_cnt = 0;
        frame_addr = 28'h0300000; frame_len = 24'd3000; frame_start = 1;
        @(negedge clk);
        frame_start = 0;
        wait_send(ok);
        pop_word(2, 2, 0, 0);
        pop_word(2, 2, 0, 0);
        rst = 1;
        @(negedge clk);
        chk("mid_rst_ctl", {busy, done, rd_req, send_en, last_flag, underflow}, 0);
        chk("mid_rst_addr", rd_addr, 0);
        chk("mid_rst_hdr", {rank_o, jpeg_len, ipv4}, 0);
        chk("mid_rst_word", wrdata, 0);
        rst = 0;
        ipv4_exp = 0;
        repeat (60) @(negedge clk);
        run_frame(28'h0400000, 20, 2, 2, 1, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
